// File: rtl/matrix_column_scanner.sv
`default_nettype none
// ============================================================================
// matrix_column_scanner : scans five latched 7-bit column patterns onto a 5x7
//                         LED matrix, one column at a time with blanking.
// Revision: 1.0 - initial release
// ============================================================================
module matrix_column_scanner #(
   parameter int unsigned DWELL_CYCLES = 1000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic [6:0] column_4,
   input  logic [6:0] column_3,
   input  logic [6:0] column_2,
   input  logic [6:0] column_1,
   input  logic [6:0] column_0,
   output logic [4:0] column_select,
   output logic [6:0] rows,
   output logic       frame_start
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_DRIVE = 2'd2
   } state_t;

   localparam logic [15:0] c_DWELL_LAST = 16'(DWELL_CYCLES - 1);
   localparam logic [15:0] c_BLANK_LAST = 16'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
   localparam state_t      c_FIRST      = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;
   localparam logic [2:0]  c_IDX_TOP    = 3'd4;

   state_t          r_state, w_state_nx;
   logic [15:0]     r_cnt, w_cnt_nx;
   logic [2:0]      r_idx, w_idx_nx;
   logic [4:0][6:0] r_shadow, w_shadow_nx;
   logic            w_fs_nx;
   logic            w_latch;
   logic [4:0]      r_col_sel, w_col_sel_nx;
   logic [6:0]      r_rows, w_rows_nx;
   logic            r_fs;

   always_comb begin
      w_state_nx  = r_state;
      w_cnt_nx    = r_cnt + 16'd1;
      w_idx_nx    = r_idx;
      w_shadow_nx = r_shadow;
      w_fs_nx     = 1'b0;
      w_latch     = 1'b0;

      case (r_state)
         S_IDLE: begin
            w_cnt_nx = '0;
            w_latch  = 1'b1;
         end
         S_BLANK: begin
            if (r_cnt == c_BLANK_LAST) begin
               w_state_nx = S_DRIVE;
               w_cnt_nx   = '0;
            end
         end
         S_DRIVE: begin
            if (r_cnt == c_DWELL_LAST) begin
               w_cnt_nx = '0;
               if (r_idx != 3'd0) begin
                  w_idx_nx   = r_idx - 3'd1;
                  w_state_nx = c_FIRST;
               end else begin
                  w_latch = 1'b1;
               end
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_cnt_nx   = '0;
         end
      endcase

      // A new frame starts either from IDLE or straight after column 0 ends
      if (w_latch && enable) begin
         w_shadow_nx = {column_4, column_3, column_2, column_1, column_0};
         w_fs_nx     = 1'b1;
         w_idx_nx    = c_IDX_TOP;
         w_cnt_nx    = '0;
         w_state_nx  = c_FIRST;
      end

      if (!enable) begin
         w_state_nx = S_IDLE;
         w_cnt_nx   = '0;
         w_idx_nx   = c_IDX_TOP;
         w_fs_nx    = 1'b0;
      end

      // Outputs are decoded from the next state so they stay fully registered
      w_col_sel_nx = '0;
      w_rows_nx    = 7'h7F;
      if (w_state_nx == S_DRIVE) begin
         w_col_sel_nx = 5'b00001 << w_idx_nx;
         w_rows_nx    = w_shadow_nx[w_idx_nx];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_idx     <= c_IDX_TOP;
         r_shadow  <= {5{7'h7F}};
         r_col_sel <= '0;
         r_rows    <= 7'h7F;
         r_fs      <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_cnt     <= w_cnt_nx;
         r_idx     <= w_idx_nx;
         r_shadow  <= w_shadow_nx;
         r_col_sel <= w_col_sel_nx;
         r_rows    <= w_rows_nx;
         r_fs      <= w_fs_nx;
      end
   end

   assign column_select = r_col_sel;
   assign rows          = r_rows;
   assign frame_start   = r_fs;

endmodule
`default_nettype wire

// File: tb/tb_matrix_column_scanner.sv
`default_nettype none
// ============================================================================
// tb_matrix_column_scanner : scoreboard bench for two scanner configurations
// Revision: 1.0 - initial release
// ============================================================================
module tb_matrix_column_scanner;

   logic       clk;
   logic       rst_n;
   logic       en_a, en_b;
   logic [6:0] c4, c3, c2, c1, c0;
   logic [4:0] cs_a, cs_b;
   logic [6:0] rw_a, rw_b;
   logic       fs_a, fs_b;

   int checks;
   int failures;

   typedef struct {
      logic [4:0] cs;
      logic [6:0] rw;
      logic       fs;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   matrix_column_scanner #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .enable(en_a),
      .column_4(c4), .column_3(c3), .column_2(c2), .column_1(c1), .column_0(c0),
      .column_select(cs_a), .rows(rw_a), .frame_start(fs_a)
   );

   matrix_column_scanner #(.DWELL_CYCLES(1), .BLANK_CYCLES(0)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .enable(en_b),
      .column_4(c4), .column_3(c3), .column_2(c2), .column_1(c1), .column_0(c0),
      .column_select(cs_b), .rows(rw_b), .frame_start(fs_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic set_cols(input logic [6:0] p4, p3, p2, p1, p0);
      c4 = p4; c3 = p3; c2 = p2; c1 = p1; c0 = p0;
   endtask

   task automatic push_idle(input bit to_b, input int n);
      exp_t e;
      e.cs = 5'b0; e.rw = 7'h7F; e.fs = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (to_b) qb.push_back(e); else qa.push_back(e);
      end
   endtask

   // Expected output stream of one frame, truncated to 'count' cycles
   task automatic push_frame(input bit to_b, input logic [6:0] p4, p3, p2, p1, p0,
                             input int nblank, input int ndwell, input int count);
      logic [6:0] p [5];
      exp_t e;
      int k;
      p[4] = p4; p[3] = p3; p[2] = p2; p[1] = p1; p[0] = p0;
      k = 0;
      for (int c = 4; c >= 0; c--) begin
         for (int b = 0; b < nblank; b++) begin
            e.cs = 5'b0; e.rw = 7'h7F; e.fs = (k == 0);
            if (k < count) begin
               if (to_b) qb.push_back(e); else qa.push_back(e);
            end
            k++;
         end
         for (int d = 0; d < ndwell; d++) begin
            e.cs = 5'(1 << c); e.rw = p[c]; e.fs = (k == 0);
            if (k < count) begin
               if (to_b) qb.push_back(e); else qa.push_back(e);
            end
            k++;
         end
      end
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      check("A.invariant", 13'(($onehot0(cs_a) && (cs_a != 0 || rw_a == 7'h7F)) ? 1 : 0), 13'd1);
      check("B.invariant", 13'(($onehot0(cs_b) && (cs_b != 0 || rw_b == 7'h7F)) ? 1 : 0), 13'd1);
      if (qa.size() > 0) begin
         e = qa.pop_front();
         check("A.cs_rows_fs", {cs_a, rw_a, fs_a}, {e.cs, e.rw, e.fs});
      end
      if (qb.size() > 0) begin
         e = qb.pop_front();
         check("B.cs_rows_fs", {cs_b, rw_b, fs_b}, {e.cs, e.rw, e.fs});
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      en_a     = 1'b1;
      en_b     = 1'b0;
      set_cols(7'h00, 7'h00, 7'h00, 7'h00, 7'h00);

      // Reset held three cycles
      push_idle(1'b0, 3);
      push_idle(1'b1, 3);
      run(3);

      // Release with filling pattern; first frame latched on the next edge
      rst_n = 1'b1;
      set_cols(7'b1101111, 7'b1011111, 7'b0000000, 7'b1011111, 7'b1101111);
      push_frame(1'b0, 7'b1101111, 7'b1011111, 7'b0000000, 7'b1011111, 7'b1101111, 2, 4, 30);
      run(30);

      // Second frame: inputs change while column 2 is driven
      push_frame(1'b0, 7'b1101111, 7'b1011111, 7'b0000000, 7'b1011111, 7'b1101111, 2, 4, 30);
      run(15);
      set_cols(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      run(15);

      // Third frame shows all-ones; restore the pattern mid-frame
      push_frame(1'b0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 2, 4, 30);
      run(15);
      set_cols(7'b1101111, 7'b1011111, 7'b0000000, 7'b1011111, 7'b1101111);
      run(15);

      // Fourth frame: drop enable during column 3 drive
      push_frame(1'b0, 7'b1101111, 7'b1011111, 7'b0000000, 7'b1011111, 7'b1101111, 2, 4, 10);
      run(10);
      en_a = 1'b0;
      push_idle(1'b0, 3);
      run(3);

      // Re-enable: fresh latch, restart at column 4
      en_a = 1'b1;
      push_frame(1'b0, 7'b1101111, 7'b1011111, 7'b0000000, 7'b1011111, 7'b1101111, 2, 4, 30);
      run(30);

      // No blanking, single-cycle dwell
      en_b = 1'b1;
      for (int f = 0; f < 3; f++)
         push_frame(1'b1, 7'b1101111, 7'b1011111, 7'b0000000, 7'b1011111, 7'b1101111, 0, 1, 5);
      run(15);
      en_b = 1'b0;
      push_idle(1'b1, 2);
      run(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
